// File: rtl/rf_dump_if.sv
// rf_dump_if: groups every signal between rf_dump_ctrl, the CPU
// (sccomp) and the snapshot sink.
//
// Signals:
//   pc, instr           CPU program counter and the instruction at pc
//   cpu_run             CPU clock enable (1 = CPU may commit this cycle)
//   reg_sel, reg_data   register-file debug read port
//   dump_valid/ready    snapshot word stream handshake
//   dump_data/last      stream word and end-of-snapshot marker
//   done, timeout       sticky status flags
//   hi, lo              extra dumped registers (only with RF_DUMP_HILO_EN)
//
// Modports: master = the controller, slave = the CPU/sink side.
//
// Stream handshake: a word moves when dump_valid and dump_ready are both
// high at a rising clk edge. Once dump_valid rises it stays high, with
// dump_data and dump_last unchanged, until that transfer happens.
interface rf_dump_if;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        cpu_run;
  logic [4:0]  reg_sel;
  logic [31:0] reg_data;
  logic        dump_valid;
  logic        dump_ready;
  logic [31:0] dump_data;
  logic        dump_last;
  logic        done;
  logic        timeout;
`ifdef RF_DUMP_HILO_EN
  logic [31:0] hi;
  logic [31:0] lo;
`endif

  modport master (
    input  pc, instr, reg_data, dump_ready,
`ifdef RF_DUMP_HILO_EN
    input  hi, lo,
`endif
    output cpu_run, reg_sel, dump_valid, dump_data, dump_last, done, timeout
  );

  modport slave (
    output pc, instr, reg_data, dump_ready,
`ifdef RF_DUMP_HILO_EN
    output hi, lo,
`endif
    input  cpu_run, reg_sel, dump_valid, dump_data, dump_last, done, timeout
  );
endinterface

// File: rtl/rf_dump_ctrl.sv
// rf_dump_ctrl: end-of-run observer for the single-cycle CPU.
//
// While running, it counts the cycles in which the CPU commits. It stops
// the CPU when pc reaches BREAK_PC, and then streams a snapshot:
// pc, instr, r0..r(NREG-1). With RF_DUMP_HILO_EN the snapshot also
// carries hi and lo. If the cycle budget MAX_CYCLES runs out first, the
// block stops the CPU and sets timeout and done without sending a stream.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   bus        rf_dump_if.master (CPU control, regfile port, stream, status)
//   dbg_state  current FSM state, for observation
//
// Optional build macro: RF_DUMP_HILO_EN adds hi/lo words after r(NREG-1).
module rf_dump_ctrl #(
  parameter logic [31:0] BREAK_PC   = 32'h0000_0048,
  parameter int unsigned MAX_CYCLES = 1000,
  parameter int unsigned NREG       = 32
) (
  input  logic            clk,
  input  logic            rst,
  rf_dump_if.master       bus,
  output logic [2:0]      dbg_state
);

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    HDR_PC    = 3'd1,
    HDR_INSTR = 3'd2,
    SEL       = 3'd3,
    LOAD      = 3'd4,
    HI        = 3'd5,
    LO        = 3'd6,
    DONE      = 3'd7
  } state_t;

  localparam logic [4:0]  LAST_SEL = 5'(NREG - 1);
  localparam logic [31:0] MAX_W    = 32'(MAX_CYCLES);

  state_t      state_q, state_d;
  logic [31:0] cnt_q;
  logic [31:0] cap_instr_q;
  logic [31:0] data_q;
  logic        last_q;
  logic [4:0]  sel_q;
  logic        done_q;
  logic        timeout_q;

  logic hit;
  logic budget_exhausted;
  logic run;
  logic xfer;
  logic is_last_sel;

  assign hit              = (bus.pc == BREAK_PC);
  assign budget_exhausted = (MAX_CYCLES != 0) && (cnt_q == MAX_W);
  // The instruction at BREAK_PC is stopped in the same cycle it appears.
  assign run              = (state_q == RUN) && !hit && !budget_exhausted;
  assign xfer             = bus.dump_valid && bus.dump_ready;
  assign is_last_sel      = (sel_q == LAST_SEL);

  assign bus.cpu_run    = run;
  assign bus.reg_sel    = sel_q;
  assign bus.dump_last  = last_q;
  assign bus.done       = done_q;
  assign bus.timeout    = timeout_q;
  assign bus.dump_valid = (state_q == HDR_PC) || (state_q == HDR_INSTR) ||
                          (state_q == LOAD)   || (state_q == HI) ||
                          (state_q == LO);
  assign dbg_state      = state_q;

`ifdef RF_DUMP_HILO_EN
  // hi/lo go to the output straight from the port in a word's first valid
  // cycle. They are registered in that same cycle, so the word stays fixed
  // while the sink applies backpressure.
  logic hl_held_q;
  assign bus.dump_data = ((state_q == HI) && !hl_held_q) ? bus.hi :
                         ((state_q == LO) && !hl_held_q) ? bus.lo : data_q;
`else
  assign bus.dump_data = data_q;
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (hit)                   state_d = HDR_PC;
        else if (budget_exhausted) state_d = DONE;
      end
      HDR_PC:    if (xfer) state_d = HDR_INSTR;
      HDR_INSTR: if (xfer) state_d = SEL;
      SEL:       state_d = LOAD;
      LOAD: begin
        if (xfer) begin
          if (!is_last_sel) state_d = SEL;
`ifdef RF_DUMP_HILO_EN
          else              state_d = HI;
`else
          else              state_d = DONE;
`endif
        end
      end
      HI:      if (xfer) state_d = LO;
      LO:      if (xfer) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Saturating count of the cycles in which the CPU committed
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           cnt_q <= '0;
    else if (run && (cnt_q != '1))     cnt_q <= cnt_q + 32'd1;
  end

  // Datapath: the capture registers, the stream word, reg_sel and the flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_instr_q <= '0;
      data_q      <= '0;
      last_q      <= 1'b0;
      sel_q       <= '0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
`ifdef RF_DUMP_HILO_EN
      hl_held_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        RUN: begin
          if (hit) begin
            // data_q holds the captured pc as the first stream word.
            data_q      <= bus.pc;
            cap_instr_q <= bus.instr;
          end else if (budget_exhausted) begin
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
          end
        end
        HDR_PC: begin
          if (xfer) data_q <= cap_instr_q;
        end
        HDR_INSTR: begin
          if (xfer) sel_q <= '0;
        end
        SEL: begin
          // r0 reads as zero whatever the register file returns.
          data_q <= (sel_q == '0) ? 32'h0 : bus.reg_data;
`ifdef RF_DUMP_HILO_EN
          last_q <= 1'b0;
`else
          last_q <= is_last_sel;
`endif
        end
        LOAD: begin
          if (xfer) begin
            last_q <= 1'b0;
            if (!is_last_sel) sel_q <= sel_q + 5'd1;
`ifndef RF_DUMP_HILO_EN
            else              done_q <= 1'b1;
`endif
          end
        end
`ifdef RF_DUMP_HILO_EN
        HI: begin
          if (xfer) begin
            hl_held_q <= 1'b0;
            last_q    <= 1'b1;
          end else if (!hl_held_q) begin
            data_q    <= bus.hi;
            hl_held_q <= 1'b1;
          end
        end
        LO: begin
          if (xfer) begin
            hl_held_q <= 1'b0;
            last_q    <= 1'b0;
            done_q    <= 1'b1;
          end else if (!hl_held_q) begin
            data_q    <= bus.lo;
            hl_held_q <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_dump_ctrl.sv
// tb_rf_dump_ctrl: self-checking bench for rf_dump_ctrl.
// The bench plays the CPU: pc advances by 4 on every cycle the CPU commits,
// and instr = pc ^ INSTR_KEY. The reference model is plain:
//   cpu_run = (pc != BREAK_PC) && (commits != MAX_CYCLES)
//   stream  = {BREAK_PC, instr(BREAK_PC), 0, rf[1..NREG-1] [, hi, lo]}
module tb_rf_dump_ctrl;

  localparam logic [31:0] BRK       = 32'h0000_0048;
  localparam logic [31:0] INSTR_KEY = 32'hA000_0000;
  localparam int          MAXC      = 1000;
`ifdef RF_DUMP_HILO_EN
  localparam int          NW        = 36;
`else
  localparam int          NW        = 34;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  rf_dump_if b ();
  rf_dump_if b2 ();
  logic [2:0] dbg_state, dbg_state2;

  rf_dump_ctrl dut (.clk(clk), .rst(rst), .bus(b), .dbg_state(dbg_state));
  rf_dump_ctrl #(.MAX_CYCLES(18)) dut2 (.clk(clk), .rst(rst), .bus(b2), .dbg_state(dbg_state2));

  logic [31:0] rf [32];
  always_comb b.reg_data  = rf[b.reg_sel];
  always_comb b2.reg_data = rf[b2.reg_sel];

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          commits = 0, commits2 = 0, brk_commits = 0;
  int          xfer_cnt = 0, words2 = 0;
  int          ready_mode = 0;
  logic [31:0] obs_words [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- CPU model (both DUTs) ----------------
  initial begin
    logic r1, r2;
    forever begin
      @(negedge clk);
      r1 = b.cpu_run && !rst;
      r2 = b2.cpu_run && !rst;
      @(posedge clk);
      #1;
      if (r1) begin
        if (b.pc == BRK) brk_commits++;
        b.pc = b.pc + 32'd4;
        b.instr = b.pc ^ INSTR_KEY;
        commits++;
      end
      if (r2) begin
        b2.pc = b2.pc + 32'd4;
        b2.instr = b2.pc ^ INSTR_KEY;
        commits2++;
      end
    end
  end

  // ---------------- sink ready driver ----------------
  initial begin
    logic [3:0] bp_pat;
    int cyc;
    bp_pat = 4'b1001;  // bit i = ready in cycle i: 1,0,0,1
    cyc = 0;
    b.dump_ready = 1'b1;
    b2.dump_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       b.dump_ready = bp_pat[cyc % 4];
        2:       b.dump_ready = ($urandom_range(0, 2) != 0);
        default: b.dump_ready = 1'b1;
      endcase
      cyc++;
    end
  end

  // ---------------- per-cycle compare process ----------------
  initial begin
    logic        held;
    logic [31:0] held_data;
    logic        held_last;
    logic [4:0]  held_sel;
    logic [31:0] e;
    held = 1'b0;
    held_data = '0;
    held_last = 1'b0;
    held_sel = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
      end else begin
        chk("cpu_run", {31'd0, b.cpu_run},
            {31'd0, (b.pc != BRK) && (commits != MAXC)});
        if (b.dump_valid) begin
          if (held) begin
            chk("hold_data", b.dump_data, held_data);
            chk("hold_last", {31'd0, b.dump_last}, {31'd0, held_last});
            chk("hold_sel", {27'd0, b.reg_sel}, {27'd0, held_sel});
          end
          if (b.dump_ready) begin
            if (exp_q.size() == 0) begin
              chk("extra_word", b.dump_data, 32'hxxxx_xxxx);
            end else begin
              e = exp_q.pop_front();
              chk("word_data", b.dump_data, e);
              chk("word_last", {31'd0, b.dump_last}, {31'd0, exp_q.size() == 0});
              if (xfer_cnt < 3) obs_words[xfer_cnt] = b.dump_data;
            end
            xfer_cnt++;
            held = 1'b0;
          end else begin
            held = 1'b1;
            held_data = b.dump_data;
            held_last = b.dump_last;
            held_sel = b.reg_sel;
          end
        end else begin
          if (held) chk("valid_dropped", 32'd0, 32'd1);
          held = 1'b0;
        end
        if (b2.dump_valid) words2++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic build_exp();
    exp_q.delete();
    exp_q.push_back(BRK);
    exp_q.push_back(BRK ^ INSTR_KEY);
    exp_q.push_back(32'h0);
    for (int i = 1; i < 32; i++) exp_q.push_back(rf[i]);
`ifdef RF_DUMP_HILO_EN
    exp_q.push_back(32'h0000_0012);
    exp_q.push_back(32'h0000_0034);
`endif
  endtask

  task automatic randomize_rf();
    rf[0] = 32'hDEAD_BEEF;
    for (int i = 1; i < 32; i++) rf[i] = $urandom;
  endtask

  // Reset is asserted and released 2 time units after a rising edge, so it
  // never coincides with a clock edge or with the CPU model's updates.
  task automatic do_reset(input logic [31:0] pc_base, input int mode);
    @(posedge clk);
    #2 rst = 1'b1;
    b.pc = pc_base;   b.instr = pc_base ^ INSTR_KEY;
    b2.pc = 32'h0;    b2.instr = INSTR_KEY;
    commits = 0; commits2 = 0; xfer_cnt = 0; words2 = 0;
    ready_mode = mode;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    while (!b.done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!b.done) chk(name, {31'd0, b.done}, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_dump_end(input string tag);
    chk({tag, "_done"}, {31'd0, b.done}, 32'd1);
    chk({tag, "_timeout"}, {31'd0, b.timeout}, 32'd0);
    chk({tag, "_words"}, xfer_cnt, NW);
    chk({tag, "_exp_left"}, exp_q.size(), 0);
    chk({tag, "_commits"}, commits, 18);
    chk({tag, "_valid_low"}, {31'd0, b.dump_valid}, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b0;
    b.pc = 32'h0;  b.instr = INSTR_KEY;
    b2.pc = 32'h0; b2.instr = INSTR_KEY;
`ifdef RF_DUMP_HILO_EN
    b.hi = 32'h0000_0012;  b.lo = 32'h0000_0034;
    b2.hi = 32'h0000_0012; b2.lo = 32'h0000_0034;
`endif
    randomize_rf();

    // Reset values
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_cpu_run", {31'd0, b.cpu_run}, 32'd1);
    chk("rst_reg_sel", {27'd0, b.reg_sel}, 32'd0);
    chk("rst_valid", {31'd0, b.dump_valid}, 32'd0);
    chk("rst_data", b.dump_data, 32'd0);
    chk("rst_last", {31'd0, b.dump_last}, 32'd0);
    chk("rst_done", {31'd0, b.done}, 32'd0);
    chk("rst_timeout", {31'd0, b.timeout}, 32'd0);
    chk("rst_state", {29'd0, dbg_state}, 32'd0);

    // Nominal dump, sink always ready; dut2 hits the break and its budget together
    do_reset(32'h0, 0);
    build_exp();
    wait_done(400, "nominal_done_wait");
    check_dump_end("nominal");
    chk("pin_word0", obs_words[0], 32'h0000_0048);
    chk("pin_word1", obs_words[1], 32'hA000_0048);
    chk("pin_word2_r0", obs_words[2], 32'h0000_0000);
    chk("dual_done", {31'd0, b2.done}, 32'd1);
    chk("dual_timeout", {31'd0, b2.timeout}, 32'd0);
    chk("dual_words", words2, NW);
    chk("dual_commits", commits2, 18);

    // Backpressure 1,0,0,1
    randomize_rf();
    do_reset(32'h0, 1);
    build_exp();
    wait_done(800, "bp_done_wait");
    check_dump_end("bp");

    // Random backpressure
    randomize_rf();
    do_reset(32'h0, 2);
    build_exp();
    wait_done(800, "rand_done_wait");
    check_dump_end("rand");

    // Reset mid-dump, then restart into a run that never hits the break
    randomize_rf();
    do_reset(32'h0, 0);
    build_exp();
    begin
      int n;
      n = 0;
      while (xfer_cnt < 10 && n < 300) begin
        @(negedge clk);
        n++;
      end
      chk("mid_reach_word10", xfer_cnt, 10);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_valid", {31'd0, b.dump_valid}, 32'd0);
    chk("mid_reg_sel", {27'd0, b.reg_sel}, 32'd0);
    chk("mid_done", {31'd0, b.done}, 32'd0);
    exp_q.delete();
    b.pc = 32'h0000_1000; b.instr = 32'h0000_1000 ^ INSTR_KEY;
    b2.pc = 32'h0;        b2.instr = INSTR_KEY;
    commits = 0; commits2 = 0; xfer_cnt = 0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_cpu_run_after", {31'd0, b.cpu_run}, 32'd1);

    // Timeout: cpu_run must fall after exactly MAXC commits, with no stream
    wait_done(1100, "timeout_done_wait");
    chk("to_done", {31'd0, b.done}, 32'd1);
    chk("to_timeout", {31'd0, b.timeout}, 32'd1);
    chk("to_commits", commits, 1000);
    chk("to_no_words", xfer_cnt, 0);
    chk("to_cpu_run", {31'd0, b.cpu_run}, 32'd0);

    chk("brk_never_committed", brk_commits, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rf_dump_ctrl.md
Name: rf_dump_ctrl

Overview:
- Hardware end-of-run observer for the single-cycle CPU (sccomp).
- Counts run cycles and halts the CPU when the PC reaches a break address. It then walks the register file through the reg_sel/reg_data debug port and streams a snapshot out on a valid/ready word stream.
- Also halts on a cycle budget timeout.
- Sits between sccomp (drives its clock enable and reg_sel) and a host/UART/trace sink.

Parameters:
- BREAK_PC, 32'h00000048, PC value that triggers halt and dump.
- MAX_CYCLES, 1000, run-cycle budget before timeout; 0 disables timeout.
- NREG, 32, number of registers dumped (index 0..NREG-1, max 32).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- pc  in  32  current CPU PC.
- instr  in  32  instruction at pc.
- cpu_run  out  1  CPU clock enable; 1 = CPU may commit this cycle.
- reg_sel  out  5  register-file debug read select (registered).
- reg_data  in  32  register-file read data, combinational from reg_sel.
- dump_valid  out  1  stream word valid.
- dump_ready  in  1  sink accepts word.
- dump_data  out  32  stream word.
- dump_last  out  1  marks final word of snapshot.
- done  out  1  snapshot complete or timeout; sticky until rst.
- timeout  out  1  budget expired without reaching BREAK_PC; sticky until rst.

Behaviour:
- Reset values: cpu_run=1 (combinational, see below), reg_sel=0, dump_valid=0, dump_data=0, dump_last=0, done=0, timeout=0, cycle counter=0, word index=0, state=RUN.
- State machine: RUN -> HDR_PC -> HDR_INSTR -> SEL -> LOAD -> (SEL | DONE). Timeout path: RUN -> DONE.
- hit = (pc == BREAK_PC). cpu_run = (state==RUN) & ~hit & ~budget_exhausted, purely combinational. The instruction at BREAK_PC never commits.
- RUN:
  - Counter increments each cycle cpu_run=1 (32-bit, saturating).
  - hit at a clock edge: latch pc and instr into capture regs, go to HDR_PC.
  - budget_exhausted = (MAX_CYCLES!=0 && counter==MAX_CYCLES). When set and not hit: timeout<=1, done<=1, go to DONE, no stream emitted.
  - hit and budget_exhausted on the same cycle: hit wins.
- HDR_PC: dump_valid=1, dump_data=captured pc. On valid&ready go to HDR_INSTR.
- HDR_INSTR: dump_data=captured instr. On handshake: reg_sel<=0, go to SEL.
- SEL: one cycle for the register-file read to settle; dump_valid=0. Go to LOAD.
- LOAD:
  - dump_data<=reg_data, except 0 when reg_sel==0 (r0 forced zero regardless of reg_data).
  - dump_valid=1; dump_last=1 when reg_sel==NREG-1.
  - On handshake: if last, done<=1 and go to DONE; else reg_sel<=reg_sel+1 and go to SEL.
- Cost per register word: minimum 2 cycles (SEL+LOAD).
- Stream length: 2+NREG words (34 default). Order: pc, instr, r0..r(NREG-1).
- Handshake:
  - Transfer occurs when dump_valid & dump_ready at a rising edge.
  - While dump_valid & ~dump_ready, dump_data, dump_last and reg_sel hold stable.
  - dump_valid never drops without a transfer.
- DONE: cpu_run=0, dump_valid=0, done=1; terminal until rst. pc/instr changes are ignored.
- rst mid-dump: everything returns to reset values immediately (async). The partial stream is abandoned and the counter restarts at 0 after release.
- reg_sel wrap: reg_sel never exceeds NREG-1; no wrap to 0 inside a dump.

Optional Feature:
- Macro: RF_DUMP_HILO_EN.
- Defined:
  - Adds input ports hi (32) and lo (32).
  - After r(NREG-1), emits two extra words hi then lo via states HI and LO.
  - dump_last moves to the lo word; stream = 4+NREG words.
  - hi/lo are sampled at each word's first valid cycle and held under backpressure.
- Undefined: no hi/lo ports; stream ends at r(NREG-1).

Test Plan:
- Nominal dump: rst pulse, program reaches pc=0x48 at run cycle 18, dump_ready=1 → cpu_run=0 in the cycle pc==0x48; 34 words = 0x00000048, instr, 0, rf[1]..rf[31]; dump_last only on word 33; done=1, timeout=0; instr at 0x48 never committed.
- Backpressure: dump_ready pattern 1,0,0,1 repeating → no dropped/duplicated words; dump_data/dump_last stable during every valid&~ready cycle; same 34-word sequence as nominal.
- Timeout: pc never equals 0x48, MAX_CYCLES=1000 → cpu_run falls after exactly 1000 run cycles; timeout=1, done=1, dump_valid never asserted.
- r0 forcing and simultaneous events: reg_data returns 0xDEADBEEF for sel 0 → word 2 = 0x00000000. Separately, MAX_CYCLES=18 with hit on cycle 18 → full dump, timeout=0.
- Reset mid-dump: assert rst after word 10 is accepted → dump_valid=0, reg_sel=0, done=0 asynchronously; after release cpu_run=1 and counter restarts from 0.
- RF_DUMP_HILO_EN: hi=0x00000012, lo=0x00000034 → words 34, 35 = 0x12, 0x34; dump_last on word 35 only.
